copper_sync_ctrl: RTL and testbench
===================================

COPPER_SYNC_CTRL -- requirements
Module: copper_sync_ctrl

Interface
REQ-001 SHALL have parameter RSTCYC, default 4: number of cycles tx_rst is held before each exchange.
REQ-002 SHALL have parameter TOWIDTH, default 24: width of the timeout counter and of the timeout input.
REQ-003 SHALL have port clk, input, 1: dspclk domain clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: strobe that begins a measurement run.
REQ-006 SHALL have port abort, input, 1: level or strobe that terminates a run.
REQ-007 SHALL have port nround, input, 8: number of exchanges per run.
REQ-008 SHALL have port timeout, input, TOWIDTH: maximum cycles to wait for a reply.
REQ-009 SHALL have port tx_stb, input, 1: the sync link has latched tx_clkcnt.
REQ-010 SHALL have port rx_stb, input, 1: the sync link has latched rx_clkcnt.
REQ-011 SHALL have port tx_clkcnt, input, 64: transmit timestamp.
REQ-012 SHALL have port rx_clkcnt, input, 64: receive timestamp.
REQ-013 SHALL have port tx_en, output, 1: line driver enable.
REQ-014 SHALL have port tx_rst, output, 1: sync link transmit reset.
REQ-015 SHALL have port busy, output, 1: a run is in progress.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at the end of a run.
REQ-017 SHALL have port err_timeout, output, 1: sticky flag, a reply was not received in time.
REQ-018 SHALL have port err_abort, output, 1: sticky flag, the last run was aborted.
REQ-019 SHALL have port round_cnt, output, 8: number of completed exchanges.
REQ-020 SHALL have ports rtt_last, rtt_min and rtt_max, output, 32 each: round-trip times in cycles.
REQ-021 SHALL have port rtt_acc, output, 40: sum of the round-trip times in the run.

Function
REQ-022 SHALL implement the states IDLE, RST, TX, WAITRX, ACC and FIN.
REQ-023 IDLE: start=1 SHALL move to RST, clear round_cnt, rtt_acc, rtt_max and both err flags, and set rtt_min to 0xFFFFFFFF.
REQ-024 RST SHALL assert tx_rst for exactly RSTCYC cycles, then move to TX.
REQ-025 TX SHALL assert tx_en and wait for tx_stb, then latch tx_clkcnt and move to WAITRX the next cycle.
REQ-026 WAITRX SHALL deassert tx_en and count cycles from 0.
REQ-027 In WAITRX, rx_stb SHALL latch rx_clkcnt and move to ACC.
REQ-028 In WAITRX, reaching the count equal to timeout without rx_stb SHALL set err_timeout and move to FIN.
REQ-029 In WAITRX, rx_stb in the same cycle as timeout expiry SHALL be accepted as a reply, with no error.
REQ-030 ACC SHALL compute rtt = (rx_clkcnt - tx_clkcnt) modulo 2^32, so wrap-around of the 64-bit counters is harmless.
REQ-031 ACC SHALL set rtt_last=rtt, update rtt_min and rtt_max, add rtt to rtt_acc with a 40-bit wrap, and increment round_cnt.
REQ-032 After ACC, the state SHALL move to FIN when round_cnt equals the effective round count, otherwise to RST.
REQ-033 The effective round count SHALL be nround, except that nround=0 SHALL be treated as 1.
REQ-034 nround SHALL be sampled at start; later changes have no effect on the run.
REQ-035 FIN SHALL pulse done for 1 cycle and return to IDLE.
REQ-036 busy SHALL be 1 in every state except IDLE.
REQ-037 start while busy SHALL be ignored.
REQ-038 tx_stb or rx_stb outside TX or WAITRX respectively SHALL be ignored.
REQ-039 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge, with tx_en=0 and tx_rst=0, err_abort=1 and no done pulse.
REQ-040 Statistics already accumulated before an abort SHALL be held.
REQ-041 abort and start together in IDLE: abort SHALL win and the run does not start.
REQ-042 tx_en, tx_rst and done SHALL be registered outputs.
REQ-043 tx_en and tx_rst SHALL never both be 1.

Reset
REQ-044 When reset=1, the state SHALL be IDLE and tx_en, tx_rst, busy, done, err_timeout, err_abort, round_cnt, rtt_last, rtt_max and rtt_acc SHALL be 0.
REQ-045 When reset=1, rtt_min SHALL be 0xFFFFFFFF.
REQ-046 Reset SHALL take priority over start and abort.
REQ-047 Reset mid-run SHALL release the line (tx_en=0) on the next edge.

Verification
REQ-048 Bench SHALL cover: nround=3; tx=100,200,300; rx=150,260,340 -> rtt_last=40, rtt_min=40, rtt_max=60, rtt_acc=150, round_cnt=3, done pulses once.
REQ-049 Bench SHALL cover: tx=0xFFFFFFF0, rx=0x1_00000010 -> rtt=0x20 (wrap).
REQ-050 Bench SHALL cover: timeout=10 with no rx_stb -> err_timeout=1, done pulse, tx_en=0, round_cnt unchanged.
REQ-051 Bench SHALL cover: rx_stb on the exact timeout cycle -> accepted, err_timeout=0.
REQ-052 Bench SHALL cover: abort in TX -> IDLE next cycle, err_abort=1, no done, tx_en=0.
REQ-053 Bench SHALL cover: nround=0 -> exactly 1 exchange; start while busy -> no restart; reset in WAITRX -> all outputs at reset values.

Source files
------------

// File: rtl/copper_sync_ctrl.sv
// Copper sync-link round-trip controller: runs nround reset/transmit/receive
// exchanges and accumulates round-trip time statistics in dspclk cycles.
module copper_sync_ctrl #(
  parameter int RSTCYC  = 4,
  parameter int TOWIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         nround,
  input  logic [TOWIDTH-1:0] timeout,
  input  logic               tx_stb,
  input  logic               rx_stb,
  input  logic [63:0]        tx_clkcnt,
  input  logic [63:0]        rx_clkcnt,
  output logic               tx_en,
  output logic               tx_rst,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               err_abort,
  output logic [7:0]         round_cnt,
  output logic [31:0]        rtt_last,
  output logic [31:0]        rtt_min,
  output logic [31:0]        rtt_max,
  output logic [39:0]        rtt_acc
);

  localparam int RCW = (RSTCYC > 1) ? $clog2(RSTCYC) : 1;

  typedef enum logic [2:0] {IDLE, RST, TX, WAITRX, ACC, FIN} state_t;

  state_t             state_reg;
  logic [RCW-1:0]     rst_cnt_reg;
  logic [TOWIDTH-1:0] wait_cnt_reg;
  logic [63:0]        tx_ts_reg;
  logic [63:0]        rx_ts_reg;
  logic [7:0]         nround_reg;

  logic [31:0] rtt_next;
  logic [7:0]  round_next;

  // Only the low 32 bits of the difference matter, so counter wrap is harmless.
  assign rtt_next   = 32'(rx_ts_reg - tx_ts_reg);
  assign round_next = round_cnt + 8'd1;
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rst_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      tx_ts_reg    <= '0;
      rx_ts_reg    <= '0;
      nround_reg   <= 8'd1;
      tx_en        <= 1'b0;
      tx_rst       <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_abort    <= 1'b0;
      round_cnt    <= '0;
      rtt_last     <= '0;
      rtt_min      <= 32'hFFFF_FFFF;
      rtt_max      <= '0;
      rtt_acc      <= '0;
    end else if (abort && (state_reg != IDLE)) begin
      state_reg <= IDLE;
      tx_en     <= 1'b0;
      tx_rst    <= 1'b0;
      done      <= 1'b0;
      err_abort <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state_reg   <= RST;
            rst_cnt_reg <= '0;
            tx_rst      <= 1'b1;
            nround_reg  <= (nround == 8'd0) ? 8'd1 : nround;
            round_cnt   <= '0;
            rtt_acc     <= '0;
            rtt_max     <= '0;
            rtt_min     <= 32'hFFFF_FFFF;
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
          end
        end
        RST: begin
          if (rst_cnt_reg == RCW'(RSTCYC - 1)) begin
            state_reg <= TX;
            tx_rst    <= 1'b0;
            tx_en     <= 1'b1;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        TX: begin
          if (tx_stb) begin
            tx_ts_reg    <= tx_clkcnt;
            wait_cnt_reg <= '0;
            tx_en        <= 1'b0;
            state_reg    <= WAITRX;
          end
        end
        WAITRX: begin
          // A reply on the expiry cycle still counts as a reply.
          if (rx_stb) begin
            rx_ts_reg <= rx_clkcnt;
            state_reg <= ACC;
          end else if (wait_cnt_reg == timeout) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state_reg   <= FIN;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ACC: begin
          rtt_last  <= rtt_next;
          rtt_acc   <= rtt_acc + {8'd0, rtt_next};
          round_cnt <= round_next;
          if (rtt_next < rtt_min) rtt_min <= rtt_next;
          if (rtt_next > rtt_max) rtt_max <= rtt_next;
          if (round_next == nround_reg) begin
            done      <= 1'b1;
            state_reg <= FIN;
          end else begin
            rst_cnt_reg <= '0;
            tx_rst      <= 1'b1;
            state_reg   <= RST;
          end
        end
        FIN: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          tx_en     <= 1'b0;
          tx_rst    <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_copper_sync_ctrl.sv
// Bench for copper_sync_ctrl: per-run expected statistics are queued as
// stimulus is issued and compared when the run finishes or is aborted.
module tb_copper_sync_ctrl;

  localparam int RSTCYC  = 4;
  localparam int TOWIDTH = 24;

  logic clk, reset, start, abort, tx_stb, rx_stb;
  logic [7:0] nround;
  logic [TOWIDTH-1:0] timeout;
  logic [63:0] tx_clkcnt, rx_clkcnt;
  logic tx_en, tx_rst, busy, done, err_timeout, err_abort;
  logic [7:0] round_cnt;
  logic [31:0] rtt_last, rtt_min, rtt_max;
  logic [39:0] rtt_acc;

  copper_sync_ctrl #(.RSTCYC(RSTCYC), .TOWIDTH(TOWIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .nround(nround),
    .timeout(timeout), .tx_stb(tx_stb), .rx_stb(rx_stb), .tx_clkcnt(tx_clkcnt),
    .rx_clkcnt(rx_clkcnt), .tx_en(tx_en), .tx_rst(tx_rst), .busy(busy),
    .done(done), .err_timeout(err_timeout), .err_abort(err_abort),
    .round_cnt(round_cnt), .rtt_last(rtt_last), .rtt_min(rtt_min),
    .rtt_max(rtt_max), .rtt_acc(rtt_acc)
  );

  typedef struct {
    logic [31:0] last, mn, mx;
    logic [39:0] acc;
    logic [7:0]  rnd;
    logic        eto, eab;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] l, mn, mx, input logic [39:0] a,
                      input logic [7:0] r, input logic eto, eab);
    exp_t e;
    e.last = l; e.mn = mn; e.mx = mx; e.acc = a; e.rnd = r; e.eto = eto; e.eab = eab;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [7:0] n);
    nround = n; start = 1'b1; tick(); start = 1'b0;
    nround = 8'd7;
  endtask

  task automatic wait_tx_en(output int nrst, output bit ok);
    int g = 0;
    nrst = 0;
    while (tx_en !== 1'b1 && g < 100) begin
      if (tx_rst === 1'b1) nrst++;
      tick(); g++;
    end
    ok = (tx_en === 1'b1);
  endtask

  task automatic tx_pulse(input logic [63:0] v);
    tx_clkcnt = v; tx_stb = 1'b1; tick(); tx_stb = 1'b0;
  endtask

  task automatic rx_after(input int d, input logic [63:0] v);
    for (int i = 0; i < d; i++) tick();
    rx_clkcnt = v; rx_stb = 1'b1; tick(); rx_stb = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b1; tick(); tick();
    start = 1'b0; abort = 1'b0;
    n_cmp++; if ({tx_en, tx_rst, busy, done, err_timeout, err_abort} !== 6'b0) begin n_bad++; $display("FAIL reset_flags: got %b required 000000", {tx_en, tx_rst, busy, done, err_timeout, err_abort}); end
    n_cmp++; if (round_cnt !== 8'd0 || rtt_last !== 32'd0 || rtt_max !== 32'd0 || rtt_acc !== 40'd0) begin n_bad++; $display("FAIL reset_stats: round=%0d last=%0d max=%0d acc=%0d required all 0", round_cnt, rtt_last, rtt_max, rtt_acc); end
    n_cmp++; if (rtt_min !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_min: got %h required ffffffff", rtt_min); end
    reset = 1'b0; tick();
    $display("reset: checked reset values");
  endtask

  task automatic test_three_rounds();
    logic [63:0] txv[3] = '{64'd100, 64'd200, 64'd300};
    logic [63:0] rxv[3] = '{64'd150, 64'd260, 64'd340};
    int nrst, cyc, d0;
    bit ok;
    exp_t e;
    push(32'd40, 32'd40, 32'd60, 40'd150, 8'd3, 1'b0, 1'b0);
    d0 = done_cnt;
    pulse_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      wait_tx_en(nrst, ok);
      n_cmp++; if (!ok || nrst != RSTCYC) begin n_bad++; $display("FAIL rst_len_round%0d: tx_en=%b rst cycles %0d required %0d", i, ok, nrst, RSTCYC); end
      tx_pulse(txv[i]);
      n_cmp++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL tx_en_waitrx%0d: got %b required 0", i, tx_en); end
      rx_after(i + 2, rxv[i]);
    end
    wait_done(ok, cyc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL three_done: no done pulse, required one"); end
    tick(); tick(); tick();
    e = sb.pop_front();
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL three_done_count: got %0d required 1", done_cnt - d0); end
    n_cmp++; if (rtt_last !== e.last || rtt_min !== e.mn || rtt_max !== e.mx) begin n_bad++; $display("FAIL three_rtt: last=%0d min=%0d max=%0d required %0d %0d %0d", rtt_last, rtt_min, rtt_max, e.last, e.mn, e.mx); end
    n_cmp++; if (rtt_acc !== e.acc || round_cnt !== e.rnd) begin n_bad++; $display("FAIL three_acc: acc=%0d round=%0d required %0d %0d", rtt_acc, round_cnt, e.acc, e.rnd); end
    n_cmp++; if (busy !== 1'b0 || err_timeout !== e.eto || err_abort !== e.eab) begin n_bad++; $display("FAIL three_flags: busy=%b eto=%b eab=%b required 0 %b %b", busy, err_timeout, err_abort, e.eto, e.eab); end
    $display("three_rounds: last=%0d min=%0d max=%0d acc=%0d round=%0d", rtt_last, rtt_min, rtt_max, rtt_acc, round_cnt);
  endtask

  task automatic test_wrap();
    int nrst, cyc;
    bit ok;
    exp_t e;
    push(32'h20, 32'h20, 32'h20, 40'h20, 8'd1, 1'b0, 1'b0);
    pulse_start(8'd1);
    wait_tx_en(nrst, ok);
    tx_pulse(64'h0000_0000_FFFF_FFF0);
    tx_pulse(64'h0);
    rx_after(1, 64'h0000_0001_0000_0010);
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_cmp++; if (!ok || rtt_last !== e.last || rtt_acc !== e.acc) begin n_bad++; $display("FAIL wrap_rtt: done=%b last=%h acc=%h required %h %h", ok, rtt_last, rtt_acc, e.last, e.acc); end
    n_cmp++; if (rtt_min !== e.mn || rtt_max !== e.mx || round_cnt !== e.rnd) begin n_bad++; $display("FAIL wrap_minmax: min=%h max=%h round=%0d required %h %h %0d", rtt_min, rtt_max, round_cnt, e.mn, e.mx, e.rnd); end
    tick();
    $display("wrap: rtt_last=%h", rtt_last);
  endtask

  task automatic test_timeout();
    int nrst, cyc;
    bit ok;
    exp_t e;
    timeout = 24'd10;
    push(32'h20, 32'hFFFF_FFFF, 32'd0, 40'd0, 8'd0, 1'b1, 1'b0);
    pulse_start(8'd1);
    wait_tx_en(nrst, ok);
    tx_pulse(64'd5000);
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_cmp++; if (!ok || cyc != 11) begin n_bad++; $display("FAIL timeout_latency: done=%b cycles %0d required 11", ok, cyc); end
    n_cmp++; if (err_timeout !== e.eto || tx_en !== 1'b0 || round_cnt !== e.rnd) begin n_bad++; $display("FAIL timeout_state: eto=%b tx_en=%b round=%0d required %b 0 %0d", err_timeout, tx_en, round_cnt, e.eto, e.rnd); end
    n_cmp++; if (rtt_min !== e.mn || rtt_last !== e.last || rtt_acc !== e.acc) begin n_bad++; $display("FAIL timeout_stats: min=%h last=%h acc=%h required %h %h %h", rtt_min, rtt_last, rtt_acc, e.mn, e.last, e.acc); end
    tick();
    $display("timeout: err_timeout=%b after %0d cycles", err_timeout, cyc);
  endtask

  task automatic test_exact_timeout();
    int nrst, cyc;
    bit ok;
    exp_t e;
    timeout = 24'd10;
    push(32'd77, 32'd77, 32'd77, 40'd77, 8'd1, 1'b0, 1'b0);
    pulse_start(8'd1);
    wait_tx_en(nrst, ok);
    tx_pulse(64'd1000);
    rx_after(10, 64'd1077);
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_cmp++; if (!ok || err_timeout !== e.eto || round_cnt !== e.rnd) begin n_bad++; $display("FAIL exact_timeout: done=%b eto=%b round=%0d required 1 %b %0d", ok, err_timeout, round_cnt, e.eto, e.rnd); end
    n_cmp++; if (rtt_last !== e.last) begin n_bad++; $display("FAIL exact_rtt: got %0d required %0d", rtt_last, e.last); end
    tick();
    timeout = 24'd1000;
    $display("exact_timeout: accepted rtt=%0d eto=%b", rtt_last, err_timeout);
  endtask

  task automatic test_abort();
    int nrst, d0;
    bit ok;
    exp_t e;
    push(32'd25, 32'd25, 32'd25, 40'd25, 8'd1, 1'b0, 1'b1);
    d0 = done_cnt;
    pulse_start(8'd2);
    wait_tx_en(nrst, ok);
    tx_pulse(64'd500);
    rx_after(3, 64'd525);
    wait_tx_en(nrst, ok);
    abort = 1'b1; tick(); abort = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (busy !== 1'b0 || tx_en !== 1'b0 || tx_rst !== 1'b0 || err_abort !== e.eab) begin n_bad++; $display("FAIL abort_state: busy=%b tx_en=%b tx_rst=%b eab=%b required 0 0 0 1", busy, tx_en, tx_rst, err_abort); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0); end
    n_cmp++; if (round_cnt !== e.rnd || rtt_last !== e.last || rtt_acc !== e.acc || rtt_min !== e.mn) begin n_bad++; $display("FAIL abort_hold: round=%0d last=%0d acc=%0d min=%0d required %0d %0d %0d %0d", round_cnt, rtt_last, rtt_acc, rtt_min, e.rnd, e.last, e.acc, e.mn); end
    $display("abort: err_abort=%b round_cnt=%0d held", err_abort, round_cnt);
  endtask

  task automatic test_abort_start_idle();
    nround = 8'd1; start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || tx_rst !== 1'b0 || err_abort !== 1'b1) begin n_bad++; $display("FAIL abort_start_idle: busy=%b tx_rst=%b eab=%b required 0 0 1", busy, tx_rst, err_abort); end
    tick();
    $display("abort_start_idle: busy=%b", busy);
  endtask

  task automatic test_nround_zero();
    int nrst, cyc;
    bit ok;
    exp_t e;
    push(32'd9, 32'd9, 32'd9, 40'd9, 8'd1, 1'b0, 1'b0);
    pulse_start(8'd0);
    wait_tx_en(nrst, ok);
    tx_pulse(64'd40);
    rx_after(2, 64'd49);
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_cmp++; if (!ok || cyc != 1 || round_cnt !== e.rnd || rtt_last !== e.last) begin n_bad++; $display("FAIL nround_zero: done=%b cyc=%0d round=%0d last=%0d required 1 1 %0d %0d", ok, cyc, round_cnt, rtt_last, e.rnd, e.last); end
    n_cmp++; if (err_abort !== e.eab) begin n_bad++; $display("FAIL nround_zero_eab: got %b required %b", err_abort, e.eab); end
    tick();
    $display("nround_zero: round_cnt=%0d", round_cnt);
  endtask

  task automatic test_back_to_back();
    int nrst, cyc;
    bit ok;
    exp_t e;
    push(32'd3, 32'd3, 32'd7, 40'd10, 8'd2, 1'b0, 1'b0);
    pulse_start(8'd2);
    wait_tx_en(nrst, ok);
    tx_pulse(64'd1000);
    rx_after(4, 64'd1007);
    tick();
    nround = 8'd1; start = 1'b1; tick(); start = 1'b0;
    wait_tx_en(nrst, ok);
    tx_pulse(64'd2000);
    rx_clkcnt = 64'd2003; rx_stb = 1'b1; tick(); rx_stb = 1'b0;
    wait_done(ok, cyc);
    e = sb.pop_front();
    n_cmp++; if (!ok || round_cnt !== e.rnd || rtt_acc !== e.acc) begin n_bad++; $display("FAIL busy_start_ignored: done=%b round=%0d acc=%0d required 1 %0d %0d", ok, round_cnt, rtt_acc, e.rnd, e.acc); end
    n_cmp++; if (rtt_min !== e.mn || rtt_max !== e.mx || rtt_last !== e.last) begin n_bad++; $display("FAIL back_to_back_rtt: min=%0d max=%0d last=%0d required %0d %0d %0d", rtt_min, rtt_max, rtt_last, e.mn, e.mx, e.last); end
    tick();
    $display("back_to_back: round_cnt=%0d acc=%0d", round_cnt, rtt_acc);
  endtask

  task automatic test_reset_waitrx();
    int nrst;
    bit ok;
    pulse_start(8'd1);
    wait_tx_en(nrst, ok);
    tx_pulse(64'd10);
    tick(); tick();
    reset = 1'b1; tick();
    n_cmp++; if ({tx_en, tx_rst, busy, done, err_timeout, err_abort} !== 6'b0) begin n_bad++; $display("FAIL reset_waitrx_flags: got %b required 000000", {tx_en, tx_rst, busy, done, err_timeout, err_abort}); end
    n_cmp++; if (round_cnt !== 8'd0 || rtt_last !== 32'd0 || rtt_max !== 32'd0 || rtt_acc !== 40'd0 || rtt_min !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_waitrx_stats: round=%0d last=%0d max=%0d acc=%0d min=%h required 0 0 0 0 ffffffff", round_cnt, rtt_last, rtt_max, rtt_acc, rtt_min); end
    reset = 1'b0; tick();
    $display("reset_waitrx: outputs at reset values");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; tx_stb = 1'b0; rx_stb = 1'b0;
    nround = 8'd0; timeout = 24'd1000; tx_clkcnt = '0; rx_clkcnt = '0;
    tick();
    test_reset();
    test_three_rounds();
    test_wrap();
    test_timeout();
    test_exact_timeout();
    test_abort();
    test_abort_start_idle();
    test_nround_zero();
    test_back_to_back();
    test_reset_waitrx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
